// File: rtl/commit_trace_queue.sv
// commit_trace_queue: ordered, stamped queue of register/memory commit events
// with a valid/ready drain and explicit drop accounting.
module commit_trace_queue #(
    parameter int DEPTH       = 16,
    parameter int DM_WORDS    = 4096,
    parameter int FILTER_ZERO = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     grf_we,
    input  logic [4:0]               grf_addr,
    input  logic [31:0]              grf_wdata,
    input  logic [31:0]              grf_pc,
    input  logic [3:0]               dm_byteen,
    input  logic [31:0]              dm_addr,
    input  logic [31:0]              dm_wdata,
    input  logic [31:0]              dm_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_kind,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_target,
    output logic [31:0]              out_data,
    output logic [31:0]              out_time,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // entry layout: {kind, pc, target, data, time}
    logic [128:0]   r_mem [DEPTH];
    logic [AW-1:0]  r_wptr, r_rptr;
    logic [CW-1:0]  r_count;
    logic [31:0]    r_stamp;
    logic           r_ovf;
    logic [15:0]    r_drop;
    logic           w_reg_ev, w_mem_ev, w_pop, w_acc_reg, w_acc_mem;
    logic [CW-1:0]  w_free;
    logic [1:0]     w_n_drop;
    logic [16:0]    w_drop_sum;
    logic [128:0]   w_reg_ent, w_mem_ent, w_head;

    assign w_reg_ev   = grf_we && (grf_addr != 5'd0 || FILTER_ZERO == 0);
    assign w_mem_ev   = (|dm_byteen) && ({2'b00, dm_addr[31:2]} < 32'(DM_WORDS));
    assign w_pop      = (r_count != '0) && out_ready;
    // a slot released by this cycle's pop can be refilled in the same cycle
    assign w_free     = CW'(DEPTH) - r_count + CW'(w_pop);
    assign w_acc_reg  = w_reg_ev && (w_free != '0);
    assign w_acc_mem  = w_mem_ev && (w_free > CW'(w_acc_reg));
    assign w_n_drop   = 2'(w_reg_ev) + 2'(w_mem_ev) - 2'(w_acc_reg) - 2'(w_acc_mem);
    assign w_drop_sum = {1'b0, r_drop} + 17'(w_n_drop);
    assign w_reg_ent  = {1'b0, grf_pc, {27'd0, grf_addr}, grf_wdata, r_stamp};
    assign w_mem_ent  = {1'b1, dm_pc, {dm_addr[31:2], 2'b00}, dm_wdata, r_stamp};
    assign w_head     = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (!reset && w_acc_reg) r_mem[r_wptr] <= w_reg_ent;
        if (!reset && w_acc_mem) r_mem[w_acc_reg ? r_wptr + AW'(1) : r_wptr] <= w_mem_ent;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_stamp <= '0;
            r_ovf   <= 1'b0;
            r_drop  <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_acc_reg) + AW'(w_acc_mem);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= r_count + CW'(w_acc_reg) + CW'(w_acc_mem) - CW'(w_pop);
            r_stamp <= r_stamp + 32'd1;
            r_ovf   <= r_ovf || (w_n_drop != 2'd0);
            r_drop  <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign out_valid  = r_count != '0;
    assign out_kind   = out_valid & w_head[128];
    assign out_pc     = out_valid ? w_head[127:96] : 32'd0;
    assign out_target = out_valid ? w_head[95:64] : 32'd0;
    assign out_data   = out_valid ? w_head[63:32] : 32'd0;
    assign out_time   = out_valid ? w_head[31:0] : 32'd0;
    assign count      = r_count;
    assign overflow   = r_ovf;
    assign drop_cnt   = r_drop;
endmodule
